// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic voice allocator: scans voices per event, then assigns/releases one
// Define VOICE_STEAL_EN to steal the oldest active voice when a note-on finds the pool full.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ev_valid,
  output logic                            ev_ready,
  input  logic                            ev_on,
  input  logic [3:0]                      ev_note,
  input  logic [2:0]                      ev_octave,
  output logic [NUM_VOICES-1:0]           voice_gate,
  output logic [4*NUM_VOICES-1:0]         voice_note,
  output logic [3*NUM_VOICES-1:0]         voice_octave,
  output logic [$clog2(NUM_VOICES+1)-1:0] busy_count,
  output logic                            steal_pulse,
  output logic                            drop_pulse
);
  localparam int IW = $clog2(NUM_VOICES);
  localparam int CW = $clog2(NUM_VOICES + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_VOICES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, APPLY, RETRIG} state_t;
  state_t state, state_next;

  logic [IW-1:0]    idx;
  logic             on_q;
  logic [3:0]       note_q;
  logic [2:0]       oct_q;
  logic             match_found, free_found, old_found;
  logic [IW-1:0]    match_idx, free_idx, old_idx;
  logic [AGE_W-1:0] old_age;
  logic [AGE_W-1:0] age [NUM_VOICES];

  logic             cur_act;
  logic [3:0]       cur_note;
  logic [2:0]       cur_oct;
  logic [AGE_W-1:0] cur_age;
  logic             full, steal, take;
  logic [IW-1:0]    tgt;
  logic [NUM_VOICES-1:0] gate_next;

  function automatic logic [CW-1:0] popcount(input logic [NUM_VOICES-1:0] g);
    logic [CW-1:0] c;
    c = '0;
    for (int v = 0; v < NUM_VOICES; v++) c = c + CW'(g[v]);
    return c;
  endfunction

  always_comb begin
    cur_act  = voice_gate[idx];
    cur_note = voice_note[4*int'(idx) +: 4];
    cur_oct  = voice_octave[3*int'(idx) +: 3];
    cur_age  = age[idx];
  end

  // Event outcome from the scan results; gate_next feeds both the gate and busy registers
  always_comb begin
    full = on_q && !match_found && !free_found;
`ifdef VOICE_STEAL_EN
    steal = full;
`else
    steal = 1'b0;
`endif
    take = on_q && (match_found || free_found || steal);
    tgt  = match_found ? match_idx : (free_found ? free_idx : old_idx);
    gate_next = voice_gate;
    if (state == APPLY) begin
      if (on_q && !match_found && free_found) gate_next[free_idx] = 1'b1;
      if (!on_q && match_found) gate_next[match_idx] = 1'b0;
      if (steal) gate_next[old_idx] = 1'b0;
    end
`ifdef VOICE_STEAL_EN
    else if (state == RETRIG) begin
      gate_next[old_idx] = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (ev_valid) state_next = SCAN;
      SCAN:  if (idx == LAST_IDX) state_next = APPLY;
`ifdef VOICE_STEAL_EN
      APPLY: state_next = steal ? RETRIG : IDLE;
`else
      APPLY: state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ev_ready = (state == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx          <= '0;
      on_q         <= 1'b0;
      note_q       <= '0;
      oct_q        <= '0;
      match_found  <= 1'b0;
      free_found   <= 1'b0;
      old_found    <= 1'b0;
      match_idx    <= '0;
      free_idx     <= '0;
      old_idx      <= '0;
      old_age      <= '0;
      voice_gate   <= '0;
      voice_note   <= '0;
      voice_octave <= '0;
      busy_count   <= '0;
      drop_pulse   <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) age[v] <= '0;
    end else begin
      drop_pulse <= 1'b0;
      voice_gate <= gate_next;
      busy_count <= popcount(gate_next);
      case (state)
        IDLE: if (ev_valid) begin
          on_q        <= ev_on;
          note_q      <= ev_note;
          oct_q       <= ev_octave;
          idx         <= '0;
          match_found <= 1'b0;
          free_found  <= 1'b0;
          old_found   <= 1'b0;
        end
        SCAN: begin
          if (!match_found && cur_act && cur_note == note_q && cur_oct == oct_q) begin
            match_found <= 1'b1;
            match_idx   <= idx;
          end
          if (!free_found && !cur_act) begin
            free_found <= 1'b1;
            free_idx   <= idx;
          end
          // Strict compare keeps the lowest index on equal ages
          if (cur_act && (!old_found || cur_age > old_age)) begin
            old_found <= 1'b1;
            old_idx   <= idx;
            old_age   <= cur_age;
          end
          idx <= idx + 1'b1;
        end
        APPLY: begin
          if (take) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
              if (IW'(v) == tgt) age[v] <= '0;
              else if (voice_gate[v] && age[v] != AGE_MAX) age[v] <= age[v] + 1'b1;
            end
          end
          if (on_q && !match_found && (free_found || steal)) begin
            voice_note[4*int'(tgt) +: 4]   <= note_q;
            voice_octave[3*int'(tgt) +: 3] <= oct_q;
          end
          if ((full && !steal) || (!on_q && !match_found)) drop_pulse <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef VOICE_STEAL_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) steal_pulse <= 1'b0;
    else        steal_pulse <= (state == APPLY) && steal;
  end
`else
  assign steal_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - table-driven, corner-case and randomized checks for voice_allocator
module tb_voice_allocator;
  localparam int N = 4;
  localparam int AGE_MAX = 255;

  logic           clk = 1'b0;
  logic           reset;
  logic           ev_valid, ev_ready, ev_on;
  logic [3:0]     ev_note;
  logic [2:0]     ev_octave;
  logic [N-1:0]   voice_gate;
  logic [4*N-1:0] voice_note;
  logic [3*N-1:0] voice_octave;
  logic [2:0]     busy_count;
  logic           steal_pulse, drop_pulse;

  int    nvec = 0;
  int    nfail = 0;
  string ctx = "";
  int    m_gate [N];
  int    m_note [N];
  int    m_oct  [N];
  int    m_age  [N];

  typedef struct {
    bit           on;
    int           note;
    int           oct;
    logic [N-1:0] gate;
    int           busy;
    bit           drop;
    bit           steal;
  } vec_t;
  vec_t tbl [10];

  always #5 clk = ~clk;

  voice_allocator #(.NUM_VOICES(N), .AGE_W(8)) dut (
    .clk(clk), .reset(reset),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on),
    .ev_note(ev_note), .ev_octave(ev_octave),
    .voice_gate(voice_gate), .voice_note(voice_note), .voice_octave(voice_octave),
    .busy_count(busy_count), .steal_pulse(steal_pulse), .drop_pulse(drop_pulse)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", ctx, name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int v = 0; v < N; v++) begin
      m_gate[v] = 0; m_note[v] = 0; m_oct[v] = 0; m_age[v] = 0;
    end
  endfunction

  function automatic logic [N-1:0] m_gate_vec();
    logic [N-1:0] g;
    for (int v = 0; v < N; v++) g[v] = (m_gate[v] != 0);
    return g;
  endfunction

  function automatic logic [4*N-1:0] m_note_vec();
    logic [4*N-1:0] r;
    for (int v = 0; v < N; v++) r[4*v +: 4] = 4'(m_note[v]);
    return r;
  endfunction

  function automatic logic [3*N-1:0] m_oct_vec();
    logic [3*N-1:0] r;
    for (int v = 0; v < N; v++) r[3*v +: 3] = 3'(m_oct[v]);
    return r;
  endfunction

  // Target voice restarts its age; every other sounding voice grows one step older
  function automatic void m_bump(input int t);
    for (int v = 0; v < N; v++)
      if (v != t && m_gate[v] != 0) m_age[v] = (m_age[v] < AGE_MAX) ? m_age[v] + 1 : AGE_MAX;
    m_age[t] = 0;
  endfunction

  function automatic void model_event(input bit on, input int note, input int oct,
                                      output bit drop, output bit steal, output int victim);
    int match = -1;
    int free = -1;
    int maxa = -1;
    drop = 1'b0; steal = 1'b0; victim = -1;
    for (int v = 0; v < N; v++) begin
      if (match < 0 && m_gate[v] != 0 && m_note[v] == note && m_oct[v] == oct) match = v;
      if (free < 0 && m_gate[v] == 0) free = v;
      if (m_gate[v] != 0 && m_age[v] > maxa) maxa = m_age[v];
    end
    if (!on) begin
      if (match >= 0) m_gate[match] = 0;
      else drop = 1'b1;
    end else if (match >= 0) begin
      m_bump(match);
    end else if (free >= 0) begin
      m_bump(free);
      m_gate[free] = 1; m_note[free] = note; m_oct[free] = oct;
    end else begin
`ifdef VOICE_STEAL_EN
      for (int v = 0; v < N; v++) if (victim < 0 && m_age[v] == maxa) victim = v;
      m_bump(victim);
      m_note[victim] = note; m_oct[victim] = oct;
      steal = 1'b1;
`else
      drop = 1'b1;
`endif
    end
  endfunction

  task automatic do_event(input bit on, input int note, input int oct,
                          output bit drop_seen, output bit steal_seen);
    int guard = 0;
    bit e_drop, e_steal;
    int victim;
    logic [N-1:0] eg;
    while (ev_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ready_idle", ev_ready, 1'b1);
    ev_valid = 1'b1; ev_on = on; ev_note = 4'(note); ev_octave = 3'(oct);
    @(posedge clk); #1;
    // Junk while busy must be ignored
    ev_on = ~on; ev_note = 4'($urandom_range(0, 11)); ev_octave = 3'($urandom);
    repeat (N) @(posedge clk);
    #1 ev_valid = 1'b0;
    @(negedge clk);
    check("ready_busy", ev_ready, 1'b0);
    model_event(on, note, oct, e_drop, e_steal, victim);
    @(negedge clk);
    drop_seen = drop_pulse;
    steal_seen = steal_pulse;
    if (e_steal) begin
      eg = m_gate_vec();
      eg[victim] = 1'b0;
      check("steal_gate_low", voice_gate, eg);
      check("steal_busy", busy_count, $countones(eg));
      check("steal_pulse", steal_pulse, 1'b1);
      check("steal_ready", ev_ready, 1'b0);
      @(negedge clk);
      check("steal_pulse_end", steal_pulse, 1'b0);
    end else begin
      check("drop_pulse", drop_pulse, e_drop);
      check("steal_none", steal_pulse, 1'b0);
    end
    check("gate", voice_gate, m_gate_vec());
    check("busy", busy_count, $countones(m_gate_vec()));
    check("note", voice_note, m_note_vec());
    check("octave", voice_octave, m_oct_vec());
    check("ready_done", ev_ready, 1'b1);
    @(negedge clk);
    check("drop_end", drop_pulse, 1'b0);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit d, s;
    reset = 1'b0; ev_valid = 1'b0; ev_on = 1'b0; ev_note = '0; ev_octave = '0;
    model_reset();

    tbl[0] = '{1'b1, 0, 4, 4'b0001, 1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 2, 4, 4'b0011, 2, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 4, 4, 4'b0111, 3, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 5, 4, 4'b1111, 4, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 2, 4, 4'b1101, 3, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 4, 4, 4'b1101, 3, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 2, 4, 4'b1111, 4, 1'b0, 1'b0};
`ifdef VOICE_STEAL_EN
    tbl[7] = '{1'b1, 7, 3, 4'b1111, 4, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 9, 2, 4'b1111, 4, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 0, 4, 4'b1111, 4, 1'b1, 1'b0};
`else
    tbl[7] = '{1'b1, 7, 3, 4'b1111, 4, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 9, 2, 4'b1111, 4, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 0, 4, 4'b1110, 3, 1'b0, 1'b0};
`endif

    repeat (2) @(negedge clk);
    ctx = "reset";
    check("gate", voice_gate, '0);
    check("busy", busy_count, '0);
    check("note", voice_note, '0);
    check("octave", voice_octave, '0);
    check("steal", steal_pulse, 1'b0);
    check("drop", drop_pulse, 1'b0);
    check("ready", ev_ready, 1'b1);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      ctx = $sformatf("vec%0d", i);
      do_event(tbl[i].on, tbl[i].note, tbl[i].oct, d, s);
      check("tbl_gate", voice_gate, tbl[i].gate);
      check("tbl_busy", busy_count, tbl[i].busy);
      check("tbl_drop", d, tbl[i].drop);
      check("tbl_steal", s, tbl[i].steal);
    end

    // Reset asserted during SCAN clears everything immediately
    ctx = "reset_scan";
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 4'd1; ev_octave = 3'd1;
    @(posedge clk); #1 ev_valid = 1'b0;
    @(posedge clk); #2 reset = 1'b0;
    #1;
    check("gate", voice_gate, '0);
    check("busy", busy_count, '0);
    check("drop", drop_pulse, 1'b0);
    check("steal", steal_pulse, 1'b0);
    check("ready", ev_ready, 1'b1);
    model_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    ctx = "after_reset";
    do_event(1'b1, 3, 1, d, s);
    check("hand_gate", voice_gate, 4'b0001);
    check("hand_note", voice_note[3:0], 4'd3);

    // Age saturation: voice0 ages past the top while voice1 is re-struck
    ctx = "age_sat";
    apply_reset();
    do_event(1'b1, 0, 0, d, s);
    do_event(1'b1, 1, 0, d, s);
    for (int k = 0; k < 253; k++) do_event(1'b1, 1, 0, d, s);
    do_event(1'b1, 2, 0, d, s);
    do_event(1'b1, 3, 0, d, s);
    do_event(1'b1, 4, 0, d, s);

    ctx = "random";
    apply_reset();
    for (int k = 0; k < 200; k++) begin
      do_event($urandom_range(0, 99) < 65, int'($urandom_range(0, 5)),
               int'($urandom_range(3, 4)), d, s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
